// File: rtl/unified_mem_responder.sv
// Unified 16-bit word memory serving a read-only fetch port and a load/store data port,
// with round-robin arbitration, programmable wait states and one-cycle acknowledges.
module unified_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [15:0]       if_data,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              l_s,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [15:0]       dm_wdata,
  output logic [15:0]       dm_rdata,
  output logic              dm_ack,
  output logic              busy
);

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam int unsigned CntW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WAIT_CYCLES);
  localparam bit NoWait = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                last_grant_q;  // 1 = data port served last
  logic                gnt_data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                store_q;
  logic [15:0]         wdata_q;
  logic [15:0]         mem [Depth];

  logic                req_any;
  logic                grant_data;
  logic                sel_data;
  logic                sel_store;
  logic                enter_resp;
  logic [ADDR_W-1:0]   sel_addr;
  logic [15:0]         sel_wdata;

  // In IDLE the transaction comes straight from the ports so a zero-wait grant can
  // respond on the very next edge; otherwise it comes from the latched copy.
  always_comb begin
    req_any    = if_req | dm_req;
    grant_data = dm_req & (~if_req | ~last_grant_q);
    sel_data   = gnt_data_q;
    sel_addr   = addr_q;
    sel_store  = store_q;
    sel_wdata  = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        sel_data   = grant_data;
        sel_addr   = grant_data ? dm_addr : if_addr;
        sel_store  = grant_data & l_s;
        sel_wdata  = dm_wdata;
        enter_resp = req_any & NoWait;
      end
      StWait:  enter_resp = (cnt_q == CntW'(1));
      default: enter_resp = 1'b0;
    endcase
  end

  // Store commits on the RESP-entry edge; a reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && sel_store) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      gnt_data_q   <= 1'b0;
      addr_q       <= '0;
      store_q      <= 1'b0;
      wdata_q      <= '0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      busy         <= 1'b0;
      if_data      <= '0;
      dm_rdata     <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (enter_resp) begin
        if_ack <= ~sel_data;
        dm_ack <= sel_data;
        if (!sel_store) begin
          if (sel_data) dm_rdata <= mem[sel_addr];
          else          if_data  <= mem[sel_addr];
        end
      end
      case (state_q)
        StIdle: begin
          if (req_any) begin
            gnt_data_q   <= grant_data;
            last_grant_q <= grant_data;
            addr_q       <= sel_addr;
            store_q      <= sel_store;
            wdata_q      <= dm_wdata;
            cnt_q        <= CntInit;
            busy         <= 1'b1;
            state_q      <= NoWait ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StResp;
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Bench for unified_mem_responder: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level model, plus directed cases with hand-computed values.
module tb_unified_mem_responder;

  localparam int unsigned AW = 8;

  typedef struct {
    bit              store;
    logic [AW-1:0]   addr;
    logic [15:0]     wdata;
  } req_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [1:0]            if_req, dm_req, l_s;
  logic [1:0][AW-1:0]    if_addr, dm_addr;
  logic [1:0][15:0]      dm_wdata;
  logic [1:0]            if_ack, dm_ack, busy;
  logic [1:0][15:0]      if_data, dm_rdata;

  always #5 clk = ~clk;

  unified_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_data(if_data[0]), .if_ack(if_ack[0]),
    .dm_req(dm_req[0]), .l_s(l_s[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_ack(dm_ack[0]), .busy(busy[0])
  );

  unified_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_data(if_data[1]), .if_ack(if_ack[1]),
    .dm_req(dm_req[1]), .l_s(l_s[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_ack(dm_ack[1]), .busy(busy[1])
  );

  // Transaction-level model: cycles left in the current transaction, round-robin history,
  // the latched request and a copy of each memory.
  int              m_rem   [2];
  bit              m_last  [2];
  bit              m_port  [2];
  logic [AW-1:0]   m_addr  [2];
  bit              m_store [2];
  logic [15:0]     m_wdata [2];
  logic [15:0]     m_mem   [2][256];
  bit              e_if_ack [2];
  bit              e_dm_ack [2];
  bit              e_busy   [2];
  logic [15:0]     e_if_data  [2];
  logic [15:0]     e_dm_rdata [2];

  logic [AW-1:0]   fq [2][$];
  req_t            dq [2][$];
  bit              a_if_act [2];
  bit              a_dm_act [2];
  bit              auto_en;
  bit              auto_gap;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    e_if_ack[k] = 1'b0;
    e_dm_ack[k] = 1'b0;
    if (reset) begin
      m_rem[k]      = 0;
      m_last[k]     = 1'b0;
      e_busy[k]     = 1'b0;
      e_if_data[k]  = '0;
      e_dm_rdata[k] = '0;
    end else begin
      if (m_rem[k] == 0) begin
        if (if_req[k] || dm_req[k]) begin
          m_port[k]  = dm_req[k] && (!if_req[k] || !m_last[k]);
          m_last[k]  = m_port[k];
          m_addr[k]  = m_port[k] ? dm_addr[k] : if_addr[k];
          m_store[k] = m_port[k] && l_s[k];
          m_wdata[k] = dm_wdata[k];
          m_rem[k]   = wc(k) + 1;
        end
      end else begin
        m_rem[k]--;
      end
      e_busy[k] = (m_rem[k] > 0);
      if (m_rem[k] == 1) begin
        if (m_port[k]) e_dm_ack[k] = 1'b1;
        else           e_if_ack[k] = 1'b1;
        if (m_store[k])     m_mem[k][m_addr[k]] = m_wdata[k];
        else if (m_port[k]) e_dm_rdata[k] = m_mem[k][m_addr[k]];
        else                e_if_data[k]  = m_mem[k][m_addr[k]];
      end
    end
  endtask

  task automatic compare(input int k);
    string p;
    p = $sformatf("u%0d c%0d", k, cyc);
    check({p, " if_ack"},   16'(if_ack[k]), 16'(e_if_ack[k]));
    check({p, " dm_ack"},   16'(dm_ack[k]), 16'(e_dm_ack[k]));
    check({p, " busy"},     16'(busy[k]),   16'(e_busy[k]));
    check({p, " if_data"},  if_data[k],     e_if_data[k]);
    check({p, " dm_rdata"}, dm_rdata[k],    e_dm_rdata[k]);
  endtask

  // Auto requester: holds req until the model's ack, scrambles fields while the
  // responder is busy (they must be ignored), presents the real request when idle.
  task automatic drive(input int k);
    req_t r;
    if (e_if_ack[k]) begin
      if (fq[k].size() > 0) fq[k].delete(0);
      a_if_act[k] = 1'b0;
    end
    if (e_dm_ack[k]) begin
      if (dq[k].size() > 0) dq[k].delete(0);
      a_dm_act[k] = 1'b0;
    end
    if (!a_if_act[k] && fq[k].size() > 0 && (!auto_gap || $urandom_range(0, 2) == 0))
      a_if_act[k] = 1'b1;
    if (!a_dm_act[k] && dq[k].size() > 0 && (!auto_gap || $urandom_range(0, 2) == 0))
      a_dm_act[k] = 1'b1;
    if_req[k] = a_if_act[k];
    dm_req[k] = a_dm_act[k];
    if (e_busy[k] || !a_if_act[k]) if_addr[k] = AW'($urandom);
    else                           if_addr[k] = fq[k][0];
    if (e_busy[k] || !a_dm_act[k]) begin
      dm_addr[k]  = AW'($urandom);
      dm_wdata[k] = 16'($urandom);
      l_s[k]      = 1'($urandom);
    end else begin
      r           = dq[k][0];
      dm_addr[k]  = r.addr;
      dm_wdata[k] = r.wdata;
      l_s[k]      = r.store;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) compare(k);
    if (auto_en) for (int k = 0; k < 2; k++) drive(k);
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_inputs();
    if_req = '0; dm_req = '0; l_s = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic run_auto(input int budget);
    int n;
    int left;
    n = 0;
    left = fq[0].size() + fq[1].size() + dq[0].size() + dq[1].size();
    while (left > 0 && n < budget) begin
      tick();
      n++;
      left = fq[0].size() + fq[1].size() + dq[0].size() + dq[1].size();
    end
    check("auto queue drain", 16'(left), 16'd0);
    ticks(3);
  endtask

  task automatic direct_store(input int k, input logic [AW-1:0] a, input logic [15:0] d);
    int n;
    dm_req[k] = 1'b1; l_s[k] = 1'b1; dm_addr[k] = a; dm_wdata[k] = d;
    n = 0;
    do begin tick(); n++; end while (!e_dm_ack[k] && n < 20);
    dm_req[k] = 1'b0;
    tick();
  endtask

  task automatic direct_load(input int k, input logic [AW-1:0] a);
    int n;
    dm_req[k] = 1'b1; l_s[k] = 1'b0; dm_addr[k] = a;
    n = 0;
    do begin tick(); n++; end while (!e_dm_ack[k] && n < 20);
    dm_req[k] = 1'b0;
    tick();
  endtask

  initial begin
    req_t r;
    zero_inputs();
    auto_en = 1'b0; auto_gap = 1'b0;
    for (int k = 0; k < 2; k++) begin a_if_act[k] = 1'b0; a_dm_act[k] = 1'b0; end
    do_reset();

    // Fill both memories, then mixed random traffic on both ports
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) begin
        r.store = 1'b1; r.addr = AW'(a); r.wdata = 16'($urandom);
        dq[k].push_back(r);
      end
    auto_en = 1'b1;
    run_auto(4000);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 80; i++) begin
        fq[k].push_back(AW'($urandom));
        r.store = 1'($urandom); r.addr = AW'($urandom_range(0, 15)); r.wdata = 16'($urandom);
        dq[k].push_back(r);
      end
    auto_gap = 1'b1;
    run_auto(8000);
    auto_en = 1'b0;
    zero_inputs();
    ticks(2);

    // Store then load 0x10, then fetch it (2 wait states)
    do_reset();
    check("rst if_ack", 16'(if_ack[0]), 16'd0);
    check("rst dm_ack", 16'(dm_ack[0]), 16'd0);
    check("rst busy", 16'(busy[0]), 16'd0);
    check("rst if_data", if_data[0], 16'h0000);
    check("rst dm_rdata", dm_rdata[0], 16'h0000);
    dm_req[0] = 1'b1; l_s[0] = 1'b1; dm_addr[0] = 8'h10; dm_wdata[0] = 16'hBEEF;
    tick();
    check("A busy c1", 16'(busy[0]), 16'd1);
    check("A dm_ack c1", 16'(dm_ack[0]), 16'd0);
    ticks(2);
    check("A store dm_ack c3", 16'(dm_ack[0]), 16'd1);
    check("A busy c3", 16'(busy[0]), 16'd1);
    l_s[0] = 1'b0;
    tick();
    check("A busy c4", 16'(busy[0]), 16'd0);
    ticks(3);
    check("A load dm_ack c7", 16'(dm_ack[0]), 16'd1);
    check("A load dm_rdata", dm_rdata[0], 16'hBEEF);
    dm_req[0] = 1'b0; if_req[0] = 1'b1; if_addr[0] = 8'h10;
    ticks(4);
    check("A fetch if_ack c11", 16'(if_ack[0]), 16'd1);
    check("A fetch if_data", if_data[0], 16'hBEEF);
    check("A dm_rdata kept", dm_rdata[0], 16'hBEEF);
    if_req[0] = 1'b0;
    tick();

    // Simultaneous requests alternate data, fetch, data, fetch
    do_reset();
    if_req[0] = 1'b1; if_addr[0] = 8'h10;
    dm_req[0] = 1'b1; l_s[0] = 1'b0; dm_addr[0] = 8'h10;
    ticks(3);
    check("B dm_ack c3", 16'(dm_ack[0]), 16'd1);
    check("B if_ack c3", 16'(if_ack[0]), 16'd0);
    ticks(4);
    check("B if_ack c7", 16'(if_ack[0]), 16'd1);
    check("B dm_ack c7", 16'(dm_ack[0]), 16'd0);
    check("B if_data c7", if_data[0], 16'hBEEF);
    ticks(4);
    check("B dm_ack c11", 16'(dm_ack[0]), 16'd1);
    check("B if_ack c11", 16'(if_ack[0]), 16'd0);
    dm_req[0] = 1'b0;
    ticks(4);
    check("B if_ack c15", 16'(if_ack[0]), 16'd1);
    if_req[0] = 1'b0;
    tick();

    // Reset during WAIT of a store leaves the old word
    do_reset();
    direct_store(0, 8'h20, 16'h1234);
    dm_req[0] = 1'b1; l_s[0] = 1'b1; dm_addr[0] = 8'h20; dm_wdata[0] = 16'hAAAA;
    tick();
    check("C busy in wait", 16'(busy[0]), 16'd1);
    reset = 1'b1; dm_req[0] = 1'b0;
    tick();
    check("C dm_ack after reset", 16'(dm_ack[0]), 16'd0);
    check("C busy after reset", 16'(busy[0]), 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("C no late dm_ack", 16'(dm_ack[0]), 16'd0);
    end
    direct_load(0, 8'h20);
    check("C old word kept", dm_rdata[0], 16'h1234);

    // Address change during WAIT is ignored
    direct_store(0, 8'h30, 16'h3030);
    direct_store(0, 8'h31, 16'h3131);
    dm_req[0] = 1'b1; l_s[0] = 1'b0; dm_addr[0] = 8'h30;
    tick();
    dm_addr[0] = 8'h31;
    ticks(2);
    check("E dm_ack", 16'(dm_ack[0]), 16'd1);
    check("E latched addr data", dm_rdata[0], 16'h3030);
    dm_req[0] = 1'b0;
    tick();

    // Zero wait states, back-to-back fetches across the top address
    direct_store(1, 8'hFE, 16'hCAFE);
    direct_store(1, 8'hFF, 16'hF00D);
    direct_store(1, 8'h00, 16'h1357);
    do_reset();
    if_req[1] = 1'b1; if_addr[1] = 8'hFE;
    tick();
    check("D if_ack c1", 16'(if_ack[1]), 16'd1);
    check("D if_data FE", if_data[1], 16'hCAFE);
    if_addr[1] = 8'hFF;
    tick();
    check("D if_ack c2", 16'(if_ack[1]), 16'd0);
    tick();
    check("D if_ack c3", 16'(if_ack[1]), 16'd1);
    check("D if_data FF", if_data[1], 16'hF00D);
    if_addr[1] = 8'h00;
    ticks(2);
    check("D if_ack c5", 16'(if_ack[1]), 16'd1);
    check("D if_data 00", if_data[1], 16'h1357);
    if_req[1] = 1'b0;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
